regfile_mp_sb: RTL and testbench

//  Parametrised multi-port register file with write-to-read bypass and a per-register busy scoreboard.

---
 rtl/regfile_mp_sb.sv | 131 +++++++++++++
 tb/tb_regfile_mp_sb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write-to-read bypass and a
// per-register busy scoreboard for decode-stage stall detection.

// One read port: forwards the highest-priority same-cycle write hit, otherwise
// returns stored data. The zero register and reset both force zeros.
module regfile_mp_sb_rdport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                 rst,
    input  logic [ADDR_W-1:0]                    addr_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs_i,
    input  logic [2**ADDR_W-1:0]                 busy_i,
    input  logic [NWR-1:0]                       wr_en_i,
    input  logic [NWR*ADDR_W-1:0]                wr_addr_i,
    input  logic [NWR*DATA_W-1:0]                wr_data_i,
    output logic [DATA_W-1:0]                    data_o,
    output logic                                 busy_o
);
    logic              hit;
    logic [DATA_W-1:0] fwd;

    // Scan write ports in ascending order so the highest matching index wins.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == addr_i)) begin
                hit = 1'b1;
                fwd = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
    end

    // Select forwarded or stored data; a forwarded value never reports busy.
    always_comb begin
        data_o = regs_i[addr_i];
        busy_o = busy_i[addr_i];
        if ((BYPASS != 0) && hit) begin
            data_o = fwd;
            busy_o = 1'b0;
        end
        if (rst || ((ZERO_REG != 0) && (addr_i == '0))) begin
            data_o = '0;
            busy_o = 1'b0;
        end
    end
endmodule

module regfile_mp_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*ADDR_W-1:0] wr_addr_i,
    input  logic [NWR*DATA_W-1:0] wr_data_i,
    input  logic                  alloc_en_i,
    input  logic [ADDR_W-1:0]     alloc_addr_i,
    input  logic                  flush_i,
    output logic [2**ADDR_W-1:0]  busy_vec_o
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;

    // Register writes: later ports overwrite earlier ones; r0 optionally hardwired.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] &&
                !((ZERO_REG != 0) && (wr_addr_i[j*ADDR_W +: ADDR_W] == '0)))
                regs_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = wr_data_i[j*DATA_W +: DATA_W];
        end
    end

    // Scoreboard: write-clear, then alloc overrides it, then flush overrides all.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j])
                busy_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (alloc_en_i && !((ZERO_REG != 0) && (alloc_addr_i == '0)))
            busy_d[alloc_addr_i] = 1'b1;
        if (flush_i)
            busy_d = '0;
    end

    // State update; reset discards any same-cycle write, alloc or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_mp_sb_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWR(NWR),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .rst       (rst),
            .addr_i    (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .data_o    (rd_data_o[k*DATA_W +: DATA_W]),
            .busy_o    (rd_busy_o[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing and a non-bypassing instance
// share stimulus and are compared every cycle against an array-based model.
module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [3:0]  alloc_addr;
    logic        flush;

    logic [31:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [15:0] busy_vec_b, busy_vec_n;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] m_mem [16];
    logic        m_busy [16];

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
        .flush_i(flush), .busy_vec_o(busy_vec_b));

    regfile_mp_sb #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
        .rd_busy_o(rd_busy_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
        .flush_i(flush), .busy_vec_o(busy_vec_n));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Is address a written this cycle? Returns the data of the last matching port.
    function automatic logic fwd_hit(input logic [3:0] a, output logic [15:0] d);
        logic h = 1'b0;
        d = '0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*4 +: 4] == a) begin
                h = 1'b1;
                d = wr_data[j*16 +: 16];
            end
        return h;
    endfunction

    function automatic logic [15:0] exp_data(input logic [3:0] a, input bit byp);
        logic [15:0] d;
        if (rst || a == 4'd0) return 16'h0;
        if (byp && fwd_hit(a, d)) return d;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a, input bit byp);
        logic [15:0] d;
        if (rst || a == 4'd0) return 1'b0;
        if (byp && fwd_hit(a, d)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Reference model: stored values and busy flags following the priority rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  <= 16'h0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            logic [15:0] nm [16];
            logic        nb [16];
            for (int i = 0; i < 16; i++) begin
                nm[i] = m_mem[i];
                nb[i] = m_busy[i];
            end
            for (int j = 0; j < 2; j++)
                if (wr_en[j]) begin
                    if (wr_addr[j*4 +: 4] != 4'd0) nm[wr_addr[j*4 +: 4]] = wr_data[j*16 +: 16];
                    nb[wr_addr[j*4 +: 4]] = 1'b0;
                end
            if (flush) for (int i = 0; i < 16; i++) nb[i] = 1'b0;
            else if (alloc_en && alloc_addr != 4'd0) nb[alloc_addr] = 1'b1;
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  <= nm[i];
                m_busy[i] <= nb[i];
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_data_b[%0d]", k), 32'(rd_data_b[k*16 +: 16]), 32'(exp_data(rd_addr[k*4 +: 4], 1'b1)));
            chk($sformatf("rd_data_n[%0d]", k), 32'(rd_data_n[k*16 +: 16]), 32'(exp_data(rd_addr[k*4 +: 4], 1'b0)));
            chk($sformatf("rd_busy_b[%0d]", k), 32'(rd_busy_b[k]), 32'(exp_busy(rd_addr[k*4 +: 4], 1'b1)));
            chk($sformatf("rd_busy_n[%0d]", k), 32'(rd_busy_n[k]), 32'(exp_busy(rd_addr[k*4 +: 4], 1'b0)));
        end
        chk("busy_vec_b", 32'(busy_vec_b), 32'(exp_vec()));
        chk("busy_vec_n", 32'(busy_vec_n), 32'(exp_vec()));
    end

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input int j, input logic [3:0] a, input logic [15:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*4 +: 4] = a;
        wr_data[j*16 +: 16] = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = 16'h0;
            m_busy[i] = 1'b0;
        end
        rst = 1'b1;
        idle();
        set_rd(4'd0, 4'd0);
        #2;
        chk("lit_reset_rd", 32'(rd_data_b), 32'h0);
        step(); step();
        rst = 1'b0;

        // 1: read every register on both ports after reset
        for (int a = 0; a < 16; a++) begin
            set_rd(4'(a), 4'(15 - a));
            step();
        end
        chk("lit_reset_vec", 32'(busy_vec_b), 32'h0);

        // 2: two ports write r5, higher port wins; bypass vs stored
        wr(0, 4'd5, 16'h1234); wr(1, 4'd5, 16'hBEEF);
        set_rd(4'd5, 4'd5);
        #1;
        chk("lit_byp_r5", 32'(rd_data_b[15:0]), 32'h0000BEEF);
        chk("lit_nobyp_old_r5", 32'(rd_data_n[15:0]), 32'h0);
        step(); idle();
        #1;
        chk("lit_nobyp_new_r5", 32'(rd_data_n[15:0]), 32'h0000BEEF);

        // 3: r0 is hardwired zero and never busy
        wr(0, 4'd0, 16'hFFFF); alloc_en = 1'b1; alloc_addr = 4'd0;
        set_rd(4'd0, 4'd5);
        #1;
        chk("lit_r0_byp", 32'(rd_data_b[15:0]), 32'h0);
        step(); idle();
        #1;
        chk("lit_r0_busy", 32'(busy_vec_b[0]), 32'h0);

        // 4: alloc r3, then write clears it with bypass
        alloc_en = 1'b1; alloc_addr = 4'd3;
        step(); idle();
        set_rd(4'd3, 4'd0);
        #1;
        chk("lit_r3_busy", 32'(rd_busy_b[0]), 32'h1);
        step();
        wr(1, 4'd3, 16'h00A5);
        #1;
        chk("lit_r3_fwd_busy", 32'(rd_busy_b[0]), 32'h0);
        chk("lit_r3_fwd_data", 32'(rd_data_b[15:0]), 32'h000000A5);
        chk("lit_r3_nobyp_busy", 32'(rd_busy_n[0]), 32'h1);
        step(); idle();
        #1;
        chk("lit_r3_cleared", 32'(busy_vec_b[3]), 32'h0);

        // 5: alloc beats write-clear; double alloc; flush beats alloc
        alloc_en = 1'b1; alloc_addr = 4'd7; wr(0, 4'd7, 16'h7777);
        set_rd(4'd7, 4'd6);
        step(); idle();
        alloc_en = 1'b1; alloc_addr = 4'd6;
        #1;
        chk("lit_r7_busy", 32'(busy_vec_b[7]), 32'h1);
        chk("lit_r7_data", 32'(rd_data_n[15:0]), 32'h00007777);
        step();
        step(); idle();
        chk("lit_r6_r7_busy", 32'(busy_vec_b), 32'h000000C0);
        flush = 1'b1; alloc_en = 1'b1; alloc_addr = 4'd9;
        step(); idle();
        #1;
        chk("lit_flush", 32'(busy_vec_b), 32'h0);

        // distinct addresses on both write ports, and write to a non-busy reg
        wr(0, 4'd10, 16'h0A0A); wr(1, 4'd11, 16'h0B0B);
        set_rd(4'd10, 4'd11);
        step(); idle();
        #1;
        chk("lit_r10_r11", 32'(rd_data_n), 32'h0B0B0A0A);
        step();

        // 6: reset mid-write clears storage and scoreboard immediately
        wr(0, 4'd2, 16'h1111); alloc_en = 1'b1; alloc_addr = 4'd12;
        set_rd(4'd2, 4'd12);
        step(); idle();
        wr(0, 4'd2, 16'h5555);
        #1;
        rst = 1'b1;
        #1;
        chk("lit_rst_rd", 32'(rd_data_b[15:0]), 32'h0);
        chk("lit_rst_vec", 32'(busy_vec_b), 32'h0);
        step();
        rst = 1'b0; idle();
        #1;
        chk("lit_after_rst_r2", 32'(rd_data_n[15:0]), 32'h0);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
